// File: rtl/rollback_arbiter.sv
// Writeback-end rollback arbiter: merges ix and dd rollback requests and
// keeps one deferred request in a hold slot. It broadcasts a single
// registered rollback to the upstream stages.
module rollback_arbiter #(
   parameter int NUM_THREADS   = 4,
   parameter int NUM_SUBCYCLES = 16,
   localparam int TW = $clog2(NUM_THREADS),
   localparam int SW = $clog2(NUM_SUBCYCLES)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          ix_instruction_valid,
   input  logic          ix_rollback_en,
   input  logic [31:0]   ix_rollback_pc,
   input  logic [TW-1:0] ix_thread_idx,
   input  logic [SW-1:0] ix_subcycle,
   input  logic          ix_privileged_op_fault,
   input  logic          dd_rollback_en,
   input  logic [31:0]   dd_rollback_pc,
   input  logic [TW-1:0] dd_thread_idx,
   input  logic [SW-1:0] dd_subcycle,
   input  logic [31:0]   cr_trap_handler,
   output logic          wb_rollback_en,
   output logic [TW-1:0] wb_rollback_thread_idx,
   output logic [31:0]   wb_rollback_pc,
   output logic [SW-1:0] wb_rollback_subcycle,
   output logic          wb_trap,
   output logic [31:0]   wb_trap_pc,
   output logic          wb_perf_rollback,
   output logic          wb_perf_dropped
);

   typedef struct packed {
      logic          vld;
      logic [TW-1:0] thread;
      logic [31:0]   pc;
      logic [SW-1:0] subcycle;
      logic          trap;
      logic [31:0]   trap_pc;
   } req_t;

   typedef enum logic {EMPTY, HELD} hold_state_t;

   hold_state_t state, state_nxt;
   req_t        hold, hold_nxt;
   req_t        ix_c, dd_c, hold_c, win;
   logic        ix_raw, dd_raw, ix_squash, dd_squash, drop;

   // Build candidates, drop squashed requests, pick the winner and the next
   // hold-slot occupant. A fault is redirected to the trap vector here so the
   // trap handler address is the one sampled at acceptance.
   always_comb begin
      ix_raw    = ix_instruction_valid && (ix_rollback_en || ix_privileged_op_fault);
      dd_raw    = dd_rollback_en;
      ix_squash = wb_rollback_en && (wb_rollback_thread_idx == ix_thread_idx);
      dd_squash = wb_rollback_en && (wb_rollback_thread_idx == dd_thread_idx);

      ix_c          = '0;
      ix_c.vld      = ix_raw && !ix_squash;
      ix_c.thread   = ix_thread_idx;
      ix_c.pc       = ix_privileged_op_fault ? cr_trap_handler : ix_rollback_pc;
      ix_c.subcycle = '0;
      ix_c.trap     = ix_privileged_op_fault;
      ix_c.trap_pc  = ix_privileged_op_fault ? ix_rollback_pc : 32'h0;

      dd_c          = '0;
      dd_c.vld      = dd_raw && !dd_squash;
      dd_c.thread   = dd_thread_idx;
      dd_c.pc       = dd_rollback_pc;
      dd_c.subcycle = dd_subcycle;

      hold_c     = hold;
      hold_c.vld = (state == HELD);

      drop      = (ix_raw && ix_squash) || (dd_raw && dd_squash);
      win       = '0;
      hold_nxt  = '0;

      if (hold_c.vld) begin
         // Held request always goes first; dd may refill the slot, ix cannot.
         win = hold_c;
         if (dd_c.vld) begin
            if (dd_c.thread == hold_c.thread) drop = 1'b1;
            else                              hold_nxt = dd_c;
         end
         if (ix_c.vld) drop = 1'b1;
      end else if (dd_c.vld) begin
         win = dd_c;
         if (ix_c.vld) begin
            if (ix_c.thread == dd_c.thread) drop = 1'b1;
            else                            hold_nxt = ix_c;
         end
      end else if (ix_c.vld) begin
         win = ix_c;
      end

      state_nxt = hold_nxt.vld ? HELD : EMPTY;
   end

   // Hold slot state and contents.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= EMPTY;
         hold  <= '0;
      end else begin
         state <= state_nxt;
         hold  <= hold_nxt;
      end
   end

   // Registered rollback broadcast and perf pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wb_rollback_en         <= 1'b0;
         wb_rollback_thread_idx <= '0;
         wb_rollback_pc         <= '0;
         wb_rollback_subcycle   <= '0;
         wb_trap                <= 1'b0;
         wb_trap_pc             <= '0;
         wb_perf_rollback       <= 1'b0;
         wb_perf_dropped        <= 1'b0;
      end else begin
         wb_rollback_en         <= win.vld;
         wb_rollback_thread_idx <= win.thread;
         wb_rollback_pc         <= win.pc;
         wb_rollback_subcycle   <= win.subcycle;
         wb_trap                <= win.trap;
         wb_trap_pc             <= win.trap_pc;
         wb_perf_rollback       <= wb_rollback_en;
         wb_perf_dropped        <= drop;
      end
   end

endmodule

// File: tb/tb_rollback_arbiter.sv
// Directed bench for rollback_arbiter with hand-computed expectations.
module tb_rollback_arbiter;

   localparam int TW = 2;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          ix_instruction_valid, ix_rollback_en, ix_privileged_op_fault;
   logic [31:0]   ix_rollback_pc;
   logic [TW-1:0] ix_thread_idx;
   logic [SW-1:0] ix_subcycle;
   logic          dd_rollback_en;
   logic [31:0]   dd_rollback_pc;
   logic [TW-1:0] dd_thread_idx;
   logic [SW-1:0] dd_subcycle;
   logic [31:0]   cr_trap_handler;
   logic          wb_rollback_en, wb_trap, wb_perf_rollback, wb_perf_dropped;
   logic [TW-1:0] wb_rollback_thread_idx;
   logic [31:0]   wb_rollback_pc, wb_trap_pc;
   logic [SW-1:0] wb_rollback_subcycle;

   int checks = 0;
   int errors = 0;

   rollback_arbiter #(.NUM_THREADS(4), .NUM_SUBCYCLES(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .ix_instruction_valid(ix_instruction_valid), .ix_rollback_en(ix_rollback_en),
      .ix_rollback_pc(ix_rollback_pc), .ix_thread_idx(ix_thread_idx),
      .ix_subcycle(ix_subcycle), .ix_privileged_op_fault(ix_privileged_op_fault),
      .dd_rollback_en(dd_rollback_en), .dd_rollback_pc(dd_rollback_pc),
      .dd_thread_idx(dd_thread_idx), .dd_subcycle(dd_subcycle),
      .cr_trap_handler(cr_trap_handler),
      .wb_rollback_en(wb_rollback_en), .wb_rollback_thread_idx(wb_rollback_thread_idx),
      .wb_rollback_pc(wb_rollback_pc), .wb_rollback_subcycle(wb_rollback_subcycle),
      .wb_trap(wb_trap), .wb_trap_pc(wb_trap_pc),
      .wb_perf_rollback(wb_perf_rollback), .wb_perf_dropped(wb_perf_dropped)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ix_instruction_valid   = 1'b0;
      ix_rollback_en         = 1'b0;
      ix_privileged_op_fault = 1'b0;
      ix_rollback_pc         = '0;
      ix_thread_idx          = '0;
      ix_subcycle            = '0;
      dd_rollback_en         = 1'b0;
      dd_rollback_pc         = '0;
      dd_thread_idx          = '0;
      dd_subcycle            = '0;
   endtask

   task automatic ix_br(input logic [TW-1:0] t, input logic [31:0] pc);
      ix_instruction_valid = 1'b1;
      ix_rollback_en       = 1'b1;
      ix_thread_idx        = t;
      ix_rollback_pc       = pc;
      ix_subcycle          = 4'd9;
   endtask

   task automatic dd_rb(input logic [TW-1:0] t, input logic [31:0] pc, input logic [SW-1:0] sc);
      dd_rollback_en = 1'b1;
      dd_thread_idx  = t;
      dd_rollback_pc = pc;
      dd_subcycle    = sc;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_en"},   {31'b0, wb_rollback_en}, 32'h0);
      chk({tag, "_thr"},  {30'b0, wb_rollback_thread_idx}, 32'h0);
      chk({tag, "_pc"},   wb_rollback_pc, 32'h0);
      chk({tag, "_sc"},   {28'b0, wb_rollback_subcycle}, 32'h0);
      chk({tag, "_trap"}, {31'b0, wb_trap}, 32'h0);
      chk({tag, "_tpc"},  wb_trap_pc, 32'h0);
      chk({tag, "_prb"},  {31'b0, wb_perf_rollback}, 32'h0);
      chk({tag, "_pdr"},  {31'b0, wb_perf_dropped}, 32'h0);
   endtask

   task automatic chk_issue(input string tag, input logic [TW-1:0] t, input logic [31:0] pc,
                            input logic [SW-1:0] sc, input logic trap);
      chk({tag, "_en"},   {31'b0, wb_rollback_en}, 32'h1);
      chk({tag, "_thr"},  {30'b0, wb_rollback_thread_idx}, {30'b0, t});
      chk({tag, "_pc"},   wb_rollback_pc, pc);
      chk({tag, "_sc"},   {28'b0, wb_rollback_subcycle}, {28'b0, sc});
      chk({tag, "_trap"}, {31'b0, wb_trap}, {31'b0, trap});
   endtask

   initial begin
      idle();
      cr_trap_handler = 32'h400;
      reset_n = 1'b0;
      tick(); tick();
      chk_zero("rst");
      reset_n = 1'b1;
      tick();
      chk_zero("post_rst");

      // Single ix branch
      ix_br(2'd1, 32'h1000);
      tick(); idle();
      chk_issue("br", 2'd1, 32'h1000, 4'd0, 1'b0);
      chk("br_prb0", {31'b0, wb_perf_rollback}, 32'h0);
      tick();
      chk("br_off", {31'b0, wb_rollback_en}, 32'h0);
      chk("br_prb1", {31'b0, wb_perf_rollback}, 32'h1);

      // ix without instruction_valid does nothing
      ix_br(2'd2, 32'h1111);
      ix_instruction_valid = 1'b0;
      tick(); idle();
      chk("noval_en", {31'b0, wb_rollback_en}, 32'h0);

      // Different-thread collision: dd wins, ix held
      dd_rb(2'd0, 32'h2000, 4'd5);
      ix_br(2'd3, 32'h3000);
      tick(); idle();
      chk_issue("col_dd", 2'd0, 32'h2000, 4'd5, 1'b0);
      tick();
      chk_issue("col_ix", 2'd3, 32'h3000, 4'd0, 1'b0);
      chk("col_pdr", {31'b0, wb_perf_dropped}, 32'h0);
      tick();
      chk("col_off", {31'b0, wb_rollback_en}, 32'h0);

      // Same-thread collision: ix dropped
      dd_rb(2'd2, 32'h2200, 4'd3);
      ix_br(2'd2, 32'h2300);
      tick(); idle();
      chk_issue("same", 2'd2, 32'h2200, 4'd3, 1'b0);
      chk("same_pdr", {31'b0, wb_perf_dropped}, 32'h1);
      tick();
      chk("same_off", {31'b0, wb_rollback_en}, 32'h0);
      chk("same_pdr0", {31'b0, wb_perf_dropped}, 32'h0);

      // Privileged-op fault redirects to trap vector
      ix_instruction_valid   = 1'b1;
      ix_privileged_op_fault = 1'b1;
      ix_thread_idx          = 2'd1;
      ix_rollback_pc         = 32'h88;
      ix_subcycle            = 4'd7;
      tick(); idle();
      cr_trap_handler = 32'h999;
      chk_issue("flt", 2'd1, 32'h400, 4'd0, 1'b1);
      chk("flt_tpc", wb_trap_pc, 32'h88);
      tick();
      chk("flt_off", {31'b0, wb_rollback_en}, 32'h0);
      chk("flt_trap0", {31'b0, wb_trap}, 32'h0);
      cr_trap_handler = 32'h400;

      // Hold occupied (thread 3) with new dd 1 / ix 0: order 2, 3, 1; ix dropped
      dd_rb(2'd2, 32'h5200, 4'd1);
      ix_br(2'd3, 32'h5300);
      tick(); idle();
      dd_rb(2'd1, 32'h5100, 4'd4);
      ix_br(2'd0, 32'h5000);
      chk_issue("h_a", 2'd2, 32'h5200, 4'd1, 1'b0);
      tick(); idle();
      chk_issue("h_b", 2'd3, 32'h5300, 4'd0, 1'b0);
      chk("h_b_pdr", {31'b0, wb_perf_dropped}, 32'h1);
      tick();
      chk_issue("h_c", 2'd1, 32'h5100, 4'd4, 1'b0);
      chk("h_c_pdr", {31'b0, wb_perf_dropped}, 32'h0);
      tick();
      chk("h_off", {31'b0, wb_rollback_en}, 32'h0);

      // Request on the thread currently being rolled back is squashed
      ix_br(2'd1, 32'h6000);
      tick(); idle();
      dd_rb(2'd1, 32'h6100, 4'd2);
      chk_issue("sq_a", 2'd1, 32'h6000, 4'd0, 1'b0);
      tick(); idle();
      chk("sq_off", {31'b0, wb_rollback_en}, 32'h0);
      chk("sq_pdr", {31'b0, wb_perf_dropped}, 32'h1);
      tick();

      // Async reset mid-burst while holding thread 2
      dd_rb(2'd0, 32'h7000, 4'd6);
      ix_br(2'd2, 32'h7200);
      tick(); idle();
      chk_issue("ar_a", 2'd0, 32'h7000, 4'd6, 1'b0);
      #2 reset_n = 1'b0;
      #1 chk_zero("ar_rst");
      #1 reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ar_quiet", {31'b0, wb_rollback_en}, 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
